// File: rtl/csi2tx_reset_seq_ctrl_if.sv
// Bundle of the sequencer's control, per-domain request/acknowledge and status signals.
// The master modport is the sequencer side and the slave modport is the system side.
interface csi2tx_reset_seq_ctrl_if #(
    parameter int NUM_DOM = 4,
    parameter int CNT_W   = 8
);
    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

    logic               sw_rst_req;
    logic [CNT_W-1:0]   rst_hold_cycles;
    logic [CNT_W-1:0]   rel_gap_cycles;
    logic [NUM_DOM-1:0] dom_rst_ack;
    logic [NUM_DOM-1:0] dom_rst_req;
    logic               seq_busy;
    logic               seq_done;
    logic               timeout_err;
    logic [IDX_W-1:0]   timeout_dom;

    modport master (
        input  sw_rst_req, rst_hold_cycles, rel_gap_cycles, dom_rst_ack,
        output dom_rst_req, seq_busy, seq_done, timeout_err, timeout_dom
    );

    modport slave (
        output sw_rst_req, rst_hold_cycles, rel_gap_cycles, dom_rst_ack,
        input  dom_rst_req, seq_busy, seq_done, timeout_err, timeout_dom
    );
endinterface

// File: rtl/csi2tx_reset_seq_ctrl.sv
// Reset sequencer for the CSI-2 TX clock domains: asserts all domain resets, holds them,
// then releases domains one by one in index order, confirming each through its acknowledge.
module csi2tx_reset_seq_ctrl #(
    parameter int NUM_DOM     = 4,
    parameter int CNT_W       = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                      clk_csi,
    input  logic                      pwr_on_rst,
    csi2tx_reset_seq_ctrl_if.master   bus
);
    localparam int IDX_W  = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ASSERT, HOLD, RELEASE, GAP, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               pending_q, pending_d;
    logic [NUM_DOM-1:0] req_q, req_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               terr_q, terr_d;
    logic [IDX_W-1:0]   tdom_q, tdom_d;

    logic               cond;
    logic               timed_out;
    logic [IDX_W-1:0]   low_zero;
    logic [IDX_W-1:0]   idx_nx;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        pending_d = pending_q;
        req_d     = req_q;
        done_d    = 1'b0;
        terr_d    = 1'b0;
        tdom_d    = tdom_q;
        cond      = 1'b0;
        low_zero  = '0;
        idx_nx    = idx_q + IDX_W'(1);

        for (int i = NUM_DOM - 1; i >= 0; i--) begin
            if (!bus.dom_rst_ack[i]) low_zero = IDX_W'(i);
        end

        if (state_q == ASSERT)       cond = &bus.dom_rst_ack;
        else if (state_q == RELEASE) cond = !bus.dom_rst_ack[idx_q];

        // A timed-out wait is treated exactly like a met condition
        timed_out = (state_q == ASSERT || state_q == RELEASE) && !cond &&
                    (wait_q >= WAIT_W'(ACK_TIMEOUT - 1));
        if ((state_q == ASSERT || state_q == RELEASE) && !cond &&
            (wait_q != WAIT_W'(ACK_TIMEOUT)))
            wait_d = wait_q + WAIT_W'(1);

        if (bus.sw_rst_req && busy_q) pending_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.sw_rst_req) begin
                    state_d = ASSERT;
                    req_d   = '1;
                    wait_d  = '0;
                end
            end
            ASSERT: begin
                if (cond || timed_out) begin
                    if (timed_out) begin
                        terr_d = 1'b1;
                        tdom_d = low_zero;
                    end
                    if (bus.rst_hold_cycles == '0) begin
                        state_d  = RELEASE;
                        idx_d    = '0;
                        req_d[0] = 1'b0;
                        wait_d   = '0;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = bus.rst_hold_cycles;
                    end
                end
            end
            HOLD: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d  = RELEASE;
                    idx_d    = '0;
                    req_d[0] = 1'b0;
                    wait_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RELEASE: begin
                if (cond || timed_out) begin
                    if (timed_out) begin
                        terr_d = 1'b1;
                        tdom_d = idx_q;
                    end
                    if (idx_q == IDX_W'(NUM_DOM - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (bus.rel_gap_cycles == '0) begin
                        idx_d         = idx_nx;
                        req_d[idx_nx] = 1'b0;
                        wait_d        = '0;
                    end else begin
                        state_d = GAP;
                        cnt_d   = bus.rel_gap_cycles;
                    end
                end
            end
            GAP: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d       = RELEASE;
                    idx_d         = idx_nx;
                    req_d[idx_nx] = 1'b0;
                    wait_d        = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                // A request landing in DONE itself is honoured like a pending one
                if (pending_q || bus.sw_rst_req) begin
                    state_d   = ASSERT;
                    req_d     = '1;
                    wait_d    = '0;
                    pending_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = ASSERT;
        endcase

        busy_d = !(state_d == IDLE || state_d == DONE);
    end

    always_ff @(posedge clk_csi or posedge pwr_on_rst) begin
        if (pwr_on_rst) begin
            state_q   <= ASSERT;
            idx_q     <= '0;
            cnt_q     <= '0;
            wait_q    <= '0;
            pending_q <= 1'b0;
            req_q     <= '1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            terr_q    <= 1'b0;
            tdom_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            pending_q <= pending_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            terr_q    <= terr_d;
            tdom_q    <= tdom_d;
        end
    end

    assign bus.dom_rst_req = req_q;
    assign bus.seq_busy    = busy_q;
    assign bus.seq_done    = done_q;
    assign bus.timeout_err = terr_q;
    assign bus.timeout_dom = tdom_q;
endmodule

// File: tb/tb_csi2tx_reset_seq_ctrl.sv
// Directed bench for csi2tx_reset_seq_ctrl: acknowledge model with 0 or 2 cycles of latency
// plus a stuck-at-1 mask; outputs sampled on the falling edge against hand-derived cycles.
module tb_csi2tx_reset_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   lat = 0;
    logic [3:0] stuck = 4'b0000;
    logic [3:0] req_d1, req_d2;

    always #5 clk = ~clk;

    csi2tx_reset_seq_ctrl_if #(.NUM_DOM(4), .CNT_W(8)) bus ();

    csi2tx_reset_seq_ctrl #(.NUM_DOM(4), .CNT_W(8), .ACK_TIMEOUT(255)) dut (
        .clk_csi    (clk),
        .pwr_on_rst (rst),
        .bus        (bus)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_d1 <= 4'b0000;
            req_d2 <= 4'b0000;
        end else begin
            req_d1 <= bus.dom_rst_req;
            req_d2 <= req_d1;
        end
    end

    always_comb bus.dom_rst_ack = ((lat == 2) ? req_d2 : bus.dom_rst_req) | stuck;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.dom_rst_req !== 4'hF) begin errors++; $display("FAIL reset_req got %h want f", bus.dom_rst_req); end
        checks++;
        if (bus.seq_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", bus.seq_busy); end
        checks++;
        if ({bus.seq_done, bus.timeout_err} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b want 00", {bus.seq_done, bus.timeout_err}); end
        checks++;
        if (bus.timeout_dom !== 2'd0) begin errors++; $display("FAIL reset_tdom got %0d want 0", bus.timeout_dom); end
    endtask

    // Acks lag requests by 2 cycles; hold 3, gap 2: releases at cycles 6, 11, 16, 21, done at 24
    task automatic test_power_on();
        logic [3:0] exp_req;
        lat = 2;
        bus.rst_hold_cycles = 8'd3;
        bus.rel_gap_cycles  = 8'd2;
        rst = 1'b0;
        for (int k = 0; k <= 25; k++) begin
            for (int i = 0; i < 4; i++) exp_req[i] = (k < 6 + 5 * i);
            checks++;
            if (bus.dom_rst_req !== exp_req) begin errors++; $display("FAIL pwr_req c%0d got %h want %h", k, bus.dom_rst_req, exp_req); end
            checks++;
            if (bus.seq_done !== (k == 24)) begin errors++; $display("FAIL pwr_done c%0d got %b want %b", k, bus.seq_done, (k == 24)); end
            checks++;
            if (bus.seq_busy !== (k < 24)) begin errors++; $display("FAIL pwr_busy c%0d got %b want %b", k, bus.seq_busy, (k < 24)); end
            @(negedge clk);
        end
    endtask

    // Request at cycle 0, ASSERT at 1, releases at 2..5, done at 6
    task automatic test_min_latency();
        logic [3:0] exp_req;
        lat = 0;
        bus.rst_hold_cycles = 8'd0;
        bus.rel_gap_cycles  = 8'd0;
        for (int k = 0; k <= 7; k++) begin
            for (int i = 0; i < 4; i++) exp_req[i] = (k >= 1) && (k < 2 + i);
            checks++;
            if (bus.dom_rst_req !== exp_req) begin errors++; $display("FAIL min_req c%0d got %h want %h", k, bus.dom_rst_req, exp_req); end
            checks++;
            if (bus.seq_done !== (k == 6)) begin errors++; $display("FAIL min_done c%0d got %b want %b", k, bus.seq_done, (k == 6)); end
            checks++;
            if (bus.seq_busy !== (k >= 1 && k <= 5)) begin errors++; $display("FAIL min_busy c%0d got %b want %b", k, bus.seq_busy, (k >= 1 && k <= 5)); end
            bus.sw_rst_req = (k == 0);
            @(negedge clk);
        end
    endtask

    // Domain 2 never drops its ack: RELEASE 2 entered at 4, timeout pulse at 4+255
    task automatic test_timeout();
        lat = 0;
        stuck = 4'b0100;
        for (int k = 0; k <= 261; k++) begin
            if (k == 258) begin
                checks++;
                if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", bus.timeout_err); end
                checks++;
                if (bus.dom_rst_req !== 4'b1000) begin errors++; $display("FAIL to_req_pre got %h want 8", bus.dom_rst_req); end
            end
            if (k == 259) begin
                checks++;
                if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_pulse got %b want 1", bus.timeout_err); end
                checks++;
                if (bus.timeout_dom !== 2'd2) begin errors++; $display("FAIL to_dom got %0d want 2", bus.timeout_dom); end
                checks++;
                if (bus.dom_rst_req !== 4'b0000) begin errors++; $display("FAIL to_req_dom3 got %h want 0", bus.dom_rst_req); end
            end
            if (k == 260) begin
                checks++;
                if ({bus.seq_done, bus.timeout_err} !== 2'b10) begin errors++; $display("FAIL to_done got %b want 10", {bus.seq_done, bus.timeout_err}); end
                checks++;
                if (bus.timeout_dom !== 2'd2) begin errors++; $display("FAIL to_dom_held got %0d want 2", bus.timeout_dom); end
            end
            if (k == 261) begin
                checks++;
                if (bus.seq_busy !== 1'b0) begin errors++; $display("FAIL to_idle got %b want 0", bus.seq_busy); end
            end
            bus.sw_rst_req = (k == 0);
            @(negedge clk);
        end
        stuck = 4'b0000;
    endtask

    // Gap 2: first done at 12, new ASSERT at 13, second done at 24
    task automatic test_sw_during_gap();
        int dones = 0;
        bus.rel_gap_cycles = 8'd2;
        for (int k = 0; k <= 28; k++) begin
            if (bus.seq_done === 1'b1) dones++;
            if (k == 12) begin
                checks++;
                if ({bus.seq_done, bus.seq_busy} !== 2'b10) begin errors++; $display("FAIL gap_done1 got %b want 10", {bus.seq_done, bus.seq_busy}); end
            end
            if (k == 13) begin
                checks++;
                if ({bus.dom_rst_req, bus.seq_busy, bus.seq_done} !== 6'b111110) begin errors++; $display("FAIL gap_reassert got %b want 111110", {bus.dom_rst_req, bus.seq_busy, bus.seq_done}); end
            end
            if (k == 24) begin
                checks++;
                if ({bus.seq_done, bus.dom_rst_req} !== 5'b10000) begin errors++; $display("FAIL gap_done2 got %b want 10000", {bus.seq_done, bus.dom_rst_req}); end
            end
            if (k == 25) begin
                checks++;
                if ({bus.seq_busy, bus.seq_done} !== 2'b00) begin errors++; $display("FAIL gap_idle got %b want 00", {bus.seq_busy, bus.seq_done}); end
            end
            bus.sw_rst_req = (k == 0 || k == 6);
            @(negedge clk);
        end
        checks++;
        if (dones !== 2) begin errors++; $display("FAIL gap_done_count got %0d want 2", dones); end
    endtask

    // Reset mid-HOLD, then restart: HOLD 1..5, releases 6..9, done at 10
    task automatic test_reset_in_hold();
        bus.rst_hold_cycles = 8'd5;
        bus.rel_gap_cycles  = 8'd0;
        for (int k = 0; k <= 3; k++) begin
            bus.sw_rst_req = (k == 0);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.dom_rst_req, bus.seq_busy, bus.seq_done} !== 6'b111110) begin errors++; $display("FAIL hold_rst got %b want 111110", {bus.dom_rst_req, bus.seq_busy, bus.seq_done}); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k <= 11; k++) begin
            if (k == 5) begin
                checks++;
                if (bus.dom_rst_req !== 4'hF) begin errors++; $display("FAIL hold_c5 got %h want f", bus.dom_rst_req); end
            end
            if (k == 6) begin
                checks++;
                if (bus.dom_rst_req !== 4'hE) begin errors++; $display("FAIL hold_c6 got %h want e", bus.dom_rst_req); end
            end
            if (k == 10) begin
                checks++;
                if ({bus.seq_done, bus.seq_busy} !== 2'b10) begin errors++; $display("FAIL hold_done got %b want 10", {bus.seq_done, bus.seq_busy}); end
            end
            @(negedge clk);
        end
    endtask

    // Three requests (1 from idle, 2 while busy) yield exactly two sequences
    task automatic test_back_to_back();
        int dones = 0;
        bus.rst_hold_cycles = 8'd0;
        for (int k = 0; k <= 20; k++) begin
            if (bus.seq_done === 1'b1) dones++;
            if (k == 7) begin
                checks++;
                if ({bus.dom_rst_req, bus.seq_busy} !== 5'b11111) begin errors++; $display("FAIL b2b_reassert got %b want 11111", {bus.dom_rst_req, bus.seq_busy}); end
            end
            if (k == 12) begin
                checks++;
                if (bus.seq_done !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %b want 1", bus.seq_done); end
            end
            if (k == 13 || k == 20) begin
                checks++;
                if (bus.seq_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle c%0d got %b want 0", k, bus.seq_busy); end
            end
            bus.sw_rst_req = (k == 0 || k == 2 || k == 4);
            @(negedge clk);
        end
        checks++;
        if (dones !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", dones); end
    endtask

    initial begin
        bus.sw_rst_req      = 1'b0;
        bus.rst_hold_cycles = 8'd0;
        bus.rel_gap_cycles  = 8'd0;
        test_reset();
        test_power_on();
        test_min_latency();
        test_timeout();
        test_sw_during_gap();
        test_reset_in_hold();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
